// File: rtl/rgb_ws2812_tx.sv
// WS2812 single-wire pixel transmitter.
// Sends GRB MSB-first with pulse-width bit coding, then holds the latch-low period.
module rgb_ws2812_tx #(
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int T_BIT        = 63,
  parameter int RESET_CYCLES = 2500,
  parameter int NUM_LEDS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(T_BIT) + 1;
  localparam int PW = $clog2(NUM_LEDS) + 1;
  localparam int LW = $clog2(RESET_CYCLES) + 1;

  localparam logic [CW-1:0] C_BIT_END = CW'(T_BIT - 1);
  localparam logic [CW-1:0] C_T0H     = CW'(T0H);
  localparam logic [CW-1:0] C_T1H     = CW'(T1H);
  localparam logic [PW-1:0] C_PIX_END = PW'(NUM_LEDS - 1);
  localparam logic [LW-1:0] C_LAT_END = LW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_LATCH
  } state_t;

  state_t        r_state;
  logic [23:0]   r_shreg;
  logic [4:0]    r_bit_idx;
  logic [CW-1:0] r_bit_cnt;
  logic [PW-1:0] r_pix_cnt;
  logic [LW-1:0] r_lat_cnt;

  logic          w_bit_end;
  logic          w_pix_end;
  logic          w_hs;
  logic          w_nxt_high;
  logic [CW-1:0] w_nxt_cnt;
  logic [23:0]   w_nxt_sh;
  logic [LW-1:0] w_lat_inc;

  assign w_bit_end = (r_bit_cnt == C_BIT_END);
  assign w_pix_end = w_bit_end && (r_bit_idx == 5'd0);
  assign w_hs      = pix_valid && pix_ready;
  assign w_nxt_cnt = w_bit_end ? '0 : r_bit_cnt + CW'(1);
  assign w_nxt_sh  = w_bit_end ? {r_shreg[22:0], 1'b0} : r_shreg;
  assign w_lat_inc = r_lat_cnt + LW'(1);

  // dout is registered, so it is derived from the counter value of the next cycle
  assign w_nxt_high = w_nxt_cnt < (w_nxt_sh[23] ? C_T1H : C_T0H);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_idx  <= '0;
      r_bit_cnt  <= '0;
      r_pix_cnt  <= '0;
      r_lat_cnt  <= '0;
      pix_ready  <= 1'b0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          pix_ready <= 1'b1;
          dout      <= 1'b0;
          busy      <= 1'b0;
          if (w_hs) begin
            r_shreg   <= {g_in, r_in, b_in};
            r_bit_idx <= 5'd23;
            r_bit_cnt <= '0;
            r_state   <= S_SEND;
            pix_ready <= 1'b0;
            busy      <= 1'b1;
            dout      <= 1'b1;
          end
        end
        S_SEND: begin
          r_bit_cnt <= w_nxt_cnt;
          r_shreg   <= w_nxt_sh;
          dout      <= w_nxt_high;
          if (w_bit_end) begin
            r_bit_idx <= r_bit_idx - 5'd1;
          end
          if (w_pix_end) begin
            dout <= 1'b0;
            if (r_pix_cnt == C_PIX_END) begin
              r_state    <= S_LATCH;
              r_lat_cnt  <= '0;
              frame_done <= (C_LAT_END == '0);
            end else begin
              r_pix_cnt <= r_pix_cnt + PW'(1);
              r_state   <= S_IDLE;
              pix_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        S_LATCH: begin
          dout <= 1'b0;
          if (r_lat_cnt == C_LAT_END) begin
            r_state   <= S_IDLE;
            r_pix_cnt <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r_lat_cnt  <= w_lat_inc;
            frame_done <= (w_lat_inc == C_LAT_END);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
